// File: rtl/aes_iter_core.sv
// Iterative AES core (NK=4/6/8): one round per clock, sequential on-chip key expansion, valid/ready on both sides.
// Optional macro AES_HEX_DEBUG_EN adds HEX2/HEX1/HEX0 showing state byte 15 in decimal; byte 0 sits in bits [127:120].
module aes_iter_core #(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [32*NK-1:0] key_in,
  output logic             key_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [127:0]     data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     data_out
`ifdef AES_HEX_DEBUG_EN
  ,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX0
`endif
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] LAST_W = 6'(4 * NR + 3);
  localparam logic [31:0] FWD_CF = 32'h02030101;
  localparam logic [31:0] INV_CF = 32'h0e0b0d09;

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]  w [NW];
  logic [5:0]   wcnt, rk_base;
  logic [2:0]   kmod;
  logic [7:0]   rcon;
  logic [3:0]   rnd, rk_idx;
  logic         mode_q;
  logic [127:0] st, rk, pre, nxt;
  logic [31:0]  prev_w, old_w, temp_w, new_w;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, sq;
    r = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = inv ? inv_sbox(s[127-8*k -: 8]) : sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  // byte k is (row k%4, column k/4); row r rotates left by r (right when inverse)
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv ? s[127-8*(4*((c-r+4)%4)+r) -: 8]
                                    : s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] cf);
    logic [127:0] o;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[127-8*(4*c+j) -: 8], cf[31-8*((j-r+4)%4) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  assign in_ready = (state == IDLE) && key_ready && !key_load;

  always_comb begin
    prev_w = w[wcnt - 6'd1];
    old_w  = w[wcnt - 6'(NK)];
    temp_w = prev_w;
    if (kmod == 3'd0)
      temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon, 24'h000000};
    else if (NK == 8 && kmod == 3'd4)
      temp_w = sub_word(prev_w);
    new_w = old_w ^ temp_w;
  end

  always_comb begin
    case (state)
      INIT:    rk_idx = mode_q ? 4'(NR) : 4'd0;
      ROUND:   rk_idx = mode_q ? 4'(NR) - rnd : rnd;
      FINAL:   rk_idx = mode_q ? 4'd0 : 4'(NR);
      default: rk_idx = 4'd0;
    endcase
    rk_base = {rk_idx, 2'b00};
    rk  = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
    pre = mode_q ? sub_bytes(shift_rows(st, 1'b1), 1'b1)
                 : shift_rows(sub_bytes(st, 1'b0), 1'b0);
    nxt = pre ^ rk;
    if (state == INIT)
      nxt = st ^ rk;
    else if (state == ROUND)
      nxt = mode_q ? mix(pre ^ rk, INV_CF) : mix(pre, FWD_CF) ^ rk;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_load) state_nxt = KEYEXP;
               else if (in_valid && in_ready) state_nxt = INIT;
      KEYEXP:  if (wcnt == LAST_W) state_nxt = IDLE;
      INIT:    state_nxt = ROUND;
      ROUND:   if (rnd == 4'(NR - 1)) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && key_load) begin
      for (int i = 0; i < NK; i++) w[i] <= key_in[32*NK-1-32*i -: 32];
    end else if (state == KEYEXP) begin
      w[wcnt] <= new_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= '0;
      mode_q    <= 1'b0;
      rnd       <= 4'd0;
      wcnt      <= 6'd0;
      kmod      <= 3'd0;
      rcon      <= 8'h00;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            key_ready <= 1'b0;
            wcnt      <= 6'(NK);
            kmod      <= 3'd0;
            rcon      <= 8'h01;
          end else if (in_valid && in_ready) begin
            st     <= data_in;
            mode_q <= mode;
          end
        end
        KEYEXP: begin
          wcnt <= wcnt + 6'd1;
          kmod <= (kmod == 3'(NK - 1)) ? 3'd0 : kmod + 3'd1;
          if (kmod == 3'd0) rcon <= xt(rcon);
          if (wcnt == LAST_W) key_ready <= 1'b1;
        end
        INIT: begin
          st  <= nxt;
          rnd <= 4'd1;
        end
        ROUND: begin
          st  <= nxt;
          rnd <= rnd + 4'd1;
        end
        FINAL: st <= nxt;
        DONE: begin
          // result is presented from the state register on the first DONE cycle
          if (!out_valid) begin
            data_out  <= st;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AES_HEX_DEBUG_EN
  Binary_to_7seg u_hex (
    .bin  (st[7:0]),
    .hex2 (HEX2),
    .hex1 (HEX1),
    .hex0 (HEX0)
  );
`endif
endmodule

`ifdef AES_HEX_DEBUG_EN
module Binary_to_7seg (
  input  logic [7:0] bin,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);
  // active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h40;  4'd1: seg = 7'h79;  4'd2: seg = 7'h24;  4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;  4'd5: seg = 7'h12;  4'd6: seg = 7'h02;  4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;  4'd9: seg = 7'h10;
      default: seg = 7'h7f;
    endcase
  endfunction

  always_comb begin
    hex2 = seg(4'(bin / 8'd100));
    hex1 = seg(4'((bin / 8'd10) % 8'd10));
    hex0 = seg(4'(bin % 8'd10));
  end
endmodule
`endif

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: AES-128/192/256 instances run side by side on FIPS-197 vectors.
module tb_aes_iter_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, key_load, in_valid, mode, out_ready;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic [2:0][127:0] din, dout;
  logic [2:0] kr, ir, ov;
`ifdef AES_HEX_DEBUG_EN
  logic [2:0][6:0] hex2, hex1, hex0;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [2:0][127:0] PT3 = {PT, PT, PT};
  localparam logic [2:0][127:0] CT = {128'h8ea2b7ca516745bfeafc49904b496089,
                                      128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                      128'h69c4e0d86a7b0430d8cdb78070b4c55a};
  int exp_lat[3] = '{12, 14, 16};
  int exp_kx[3]  = '{40, 46, 52};

  aes_iter_core #(.NK(4)) u4 (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key4), .key_ready(kr[0]),
    .in_valid(in_valid), .in_ready(ir[0]), .mode(mode), .data_in(din[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .data_out(dout[0])
`ifdef AES_HEX_DEBUG_EN
    , .HEX2(hex2[0]), .HEX1(hex1[0]), .HEX0(hex0[0])
`endif
  );
  aes_iter_core #(.NK(6)) u6 (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key6), .key_ready(kr[1]),
    .in_valid(in_valid), .in_ready(ir[1]), .mode(mode), .data_in(din[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .data_out(dout[1])
`ifdef AES_HEX_DEBUG_EN
    , .HEX2(hex2[1]), .HEX1(hex1[1]), .HEX0(hex0[1])
`endif
  );
  aes_iter_core #(.NK(8)) u8 (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key8), .key_ready(kr[2]),
    .in_valid(in_valid), .in_ready(ir[2]), .mode(mode), .data_in(din[2]),
    .out_valid(ov[2]), .out_ready(out_ready), .data_out(dout[2])
`ifdef AES_HEX_DEBUG_EN
    , .HEX2(hex2[2]), .HEX1(hex1[2]), .HEX0(hex0[2])
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_keys(input string tag);
    int n;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    n = 0;
    while (kr !== 3'b111 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (kr !== 3'b111) begin
      errors++;
      $display("FAIL %s key_ready timeout got %b want 111", tag, kr);
    end
  endtask

  // offers a block to all three cores, leaves them holding the result with out_ready low
  task automatic run_block(input logic m, input logic [2:0][127:0] blk,
                           input logic [2:0][127:0] exp, input string tag);
    int lat[3];
    int c;
    checks++;
    if (ir !== 3'b111) begin
      errors++;
      $display("FAIL %s in_ready got %b want 111", tag, ir);
    end
    din = blk; mode = m; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    mode = ~m;
    for (int i = 0; i < 3; i++) din[i] = {$urandom, $urandom, $urandom, $urandom};
    checks++;
    if (ir !== 3'b000 || ov !== 3'b000) begin
      errors++;
      $display("FAIL %s busy after accept got ir=%b ov=%b want 000/000", tag, ir, ov);
    end
    lat = '{0, 0, 0};
    c = 0;
    while (ov !== 3'b111 && c < 40) begin
      step();
      c++;
      for (int i = 0; i < 3; i++) if (ov[i] && lat[i] == 0) lat[i] = c;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lat[i] != exp_lat[i]) begin
        errors++;
        $display("FAIL %s latency[%0d] got %0d want %0d", tag, i, lat[i], exp_lat[i]);
      end
      checks++;
      if (dout[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s data_out[%0d] got %h want %h", tag, i, dout[i], exp[i]);
      end
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (ov !== 3'b000 || ir !== 3'b111) begin
      errors++;
      $display("FAIL %s handshake got ov=%b ir=%b want 000/111", tag, ov, ir);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (kr !== 3'b000) begin errors++; $display("FAIL reset key_ready got %b want 000", kr); end
    checks++;
    if (ir !== 3'b000) begin errors++; $display("FAIL reset in_ready got %b want 000", ir); end
    checks++;
    if (ov !== 3'b000) begin errors++; $display("FAIL reset out_valid got %b want 000", ov); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dout[i] !== 128'h0) begin
        errors++;
        $display("FAIL reset data_out[%0d] got %h want 0", i, dout[i]);
      end
    end
`ifdef AES_HEX_DEBUG_EN
    checks++;
    if (hex2[0] !== 7'h40 || hex1[0] !== 7'h40 || hex0[0] !== 7'h40) begin
      errors++;
      $display("FAIL reset hex got %h %h %h want 40 40 40", hex2[0], hex1[0], hex0[0]);
    end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_key_expansion();
    int first[3];
    first = '{0, 0, 0};
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      step();
      for (int i = 0; i < 3; i++) if (kr[i] && first[i] == 0) first[i] = c;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (first[i] != exp_kx[i]) begin
        errors++;
        $display("FAIL keyexp cycles[%0d] got %0d want %0d", i, first[i], exp_kx[i]);
      end
    end
  endtask

  task automatic test_encrypt();
    run_block(1'b0, PT3, CT, "enc");
`ifdef AES_HEX_DEBUG_EN
    checks++;
    if (hex2[0] !== 7'h40 || hex1[0] !== 7'h10 || hex0[0] !== 7'h40) begin
      errors++;
      $display("FAIL hex 090 got %h %h %h want 40 10 40", hex2[0], hex1[0], hex0[0]);
    end
`endif
    consume("enc");
  endtask

  task automatic test_decrypt();
    run_block(1'b1, CT, PT3, "dec");
    consume("dec");
  endtask

  task automatic test_backpressure();
    run_block(1'b0, PT3, CT, "bp");
    for (int k = 0; k < 5; k++) begin
      if (k == 2) key_load = 1'b1;
      step();
      key_load = 1'b0;
      checks++;
      if (dout[0] !== CT[0] || ov !== 3'b111 || ir !== 3'b000 || kr !== 3'b111) begin
        errors++;
        $display("FAIL bp hold cycle %0d got dout=%h ov=%b ir=%b kr=%b want %h 111 000 111",
                 k, dout[0], ov, ir, kr, CT[0]);
      end
    end
    consume("bp");
    run_block(1'b1, CT, PT3, "bp_next");
    consume("bp_next");
  endtask

  task automatic test_collision();
    int n;
    din = PT3; mode = 1'b0; in_valid = 1'b1; key_load = 1'b1;
    step();
    in_valid = 1'b0; key_load = 1'b0;
    checks++;
    if (kr !== 3'b000 || ir !== 3'b000) begin
      errors++;
      $display("FAIL collide keyexp got kr=%b ir=%b want 000/000", kr, ir);
    end
    load_wait: begin
      n = 0;
      while (kr !== 3'b111 && n < 100) begin step(); n++; end
    end
    checks++;
    if (kr !== 3'b111 || ov !== 3'b000 || ir !== 3'b111) begin
      errors++;
      $display("FAIL collide no_accept got kr=%b ov=%b ir=%b want 111 000 111", kr, ov, ir);
    end
    din = PT3; mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    n = 0;
    while (ov !== 3'b111 && n < 40) begin step(); n++; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dout[i] !== CT[i] || kr[i] !== 1'b1) begin
        errors++;
        $display("FAIL midblock key_load[%0d] got %h kr=%b want %h kr=1", i, dout[i], kr[i], CT[i]);
      end
    end
    consume("midblock");
  endtask

  task automatic test_reset_mid();
    din = PT3; mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    checks++;
    if (kr !== 3'b000 || ov !== 3'b000 || dout !== '0) begin
      errors++;
      $display("FAIL rst_round got kr=%b ov=%b dout0=%h want 000 000 0", kr, ov, dout[0]);
    end
    rst = 1'b0;
    step();
    load_keys("rst_round");
    run_block(1'b0, PT3, CT, "after_rst_round");
    consume("after_rst_round");

    key_load = 1'b1;
    step();
    key_load = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    checks++;
    if (kr !== 3'b000 || ov !== 3'b000 || dout !== '0) begin
      errors++;
      $display("FAIL rst_keyexp got kr=%b ov=%b dout0=%h want 000 000 0", kr, ov, dout[0]);
    end
    rst = 1'b0;
    repeat (50) step();
    checks++;
    if (kr !== 3'b000) begin
      errors++;
      $display("FAIL rst_keyexp stays_cleared got kr=%b want 000", kr);
    end
    load_keys("rst_keyexp");
    run_block(1'b0, PT3, CT, "after_rst_keyexp");
    consume("after_rst_keyexp");
  endtask

  initial begin
    rst = 1'b1; key_load = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b0;
    din = '0;
    key4 = 128'h000102030405060708090a0b0c0d0e0f;
    key6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    key8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    test_reset();
    test_key_expansion();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
